// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmit FSM states and frame limits.
package uart_pkg;

  localparam int unsigned UART_MIN_DATA  = 5;
  localparam int unsigned UART_MAX_FRAME = 13;

  typedef enum logic [2:0] {
    ParNone  = 3'd0,
    ParOdd   = 3'd1,
    ParEven  = 3'd2,
    ParMark  = 3'd3,
    ParSpace = 3'd4
  } uart_parity_e;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

endpackage

// File: rtl/uart_tx_frame_engine_if.sv
// Valid/ready word handshake between the TX FIFO/host side and the frame engine.
interface uart_tx_frame_engine_if #(
  parameter int unsigned DATA_MAX = 9
);
  logic [DATA_MAX-1:0] s_data;
  logic                s_valid;
  logic                s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/uart_parity_gen.sv
// Combinational masked parity over the low 'len' bits, plus a config legality flag.
module uart_parity_gen
  import uart_pkg::*;
#(
  parameter int unsigned DATA_MAX = 9,
  parameter int unsigned LEN_W    = 4
) (
  input  logic [DATA_MAX-1:0] data,
  input  logic [LEN_W-1:0]    len,
  input  logic [2:0]          mode,
  output logic                parity,
  output logic                illegal
);

  logic xor_red;

  always_comb begin
    xor_red = 1'b0;
    for (int i = 0; i < int'(DATA_MAX); i++) begin
      if (i < int'(len)) xor_red = xor_red ^ data[i];
    end
  end

  always_comb begin
    parity = 1'b0;
    case (mode)
      ParOdd:  parity = ~xor_red;
      ParEven: parity = xor_red;
      ParMark: parity = 1'b1;
      default: parity = 1'b0;
    endcase
  end

  assign illegal = (len < LEN_W'(UART_MIN_DATA)) || (len > LEN_W'(DATA_MAX)) ||
                   (mode > 3'(ParSpace));

endmodule

// File: rtl/uart_tx_frame_engine.sv
// UART transmit engine: one-deep holding register, per-frame config sampling and
// LSB-first serialisation of start/data/parity/stop bits on baud_tick.
module uart_tx_frame_engine
  import uart_pkg::*;
#(
  parameter int unsigned DATA_MAX = 9,
  parameter int unsigned LEN_W    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    baud_tick,
  input  logic [LEN_W-1:0]        cfg_data_len,
  input  logic [2:0]              cfg_parity,
  input  logic                    cfg_stop2,
  uart_tx_frame_engine_if.slave   s,
  output logic                    tx,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    cfg_err
);

  localparam int unsigned CNT_W = $clog2(DATA_MAX + 1);

  tx_state_e           state_q, state_d;
  logic [DATA_MAX-1:0] hold_data_q, hold_data_d;
  logic                hold_full_q, hold_full_d;
  logic [DATA_MAX-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                par_en_q, par_en_d;
  logic                par_bit_q, par_bit_d;
  logic                stop2_q, stop2_d;
  logic                stop_cnt_q, stop_cnt_d;
  logic                tx_q, tx_d;
  logic                frame_done_q, frame_done_d;
  logic                cfg_err_q, cfg_err_d;
  logic                start_pt;
  logic                par_calc;
  logic                cfg_illegal;

  // Parity and legality are evaluated on the held word with the live config,
  // and only latched at the frame start point.
  uart_parity_gen #(
    .DATA_MAX (DATA_MAX),
    .LEN_W    (LEN_W)
  ) u_parity_gen (
    .data    (hold_data_q),
    .len     (cfg_data_len),
    .mode    (cfg_parity),
    .parity  (par_calc),
    .illegal (cfg_illegal)
  );

  always_comb begin
    state_d      = state_q;
    hold_data_d  = hold_data_q;
    hold_full_d  = hold_full_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    par_en_d     = par_en_q;
    par_bit_d    = par_bit_q;
    stop2_d      = stop2_q;
    stop_cnt_d   = stop_cnt_q;
    tx_d         = tx_q;
    frame_done_d = 1'b0;
    cfg_err_d    = 1'b0;
    start_pt     = 1'b0;

    if (s.s_valid && !hold_full_q) begin
      hold_full_d = 1'b1;
      hold_data_d = s.s_data;
    end

    if (baud_tick) begin
      case (state_q)
        StIdle:  start_pt = 1'b1;
        StStart: begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = CNT_W'(1);
          state_d = StData;
        end
        StData: begin
          if (int'(cnt_q) == int'(len_q)) begin
            if (par_en_q) begin
              tx_d    = par_bit_q;
              state_d = StParity;
            end else begin
              tx_d       = 1'b1;
              stop_cnt_d = 1'b0;
              state_d    = StStop;
            end
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        StParity: begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = StStop;
        end
        StStop: begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            frame_done_d = 1'b1;
            tx_d         = 1'b1;
            state_d      = StIdle;
            start_pt     = 1'b1;
          end
        end
        default: begin
          tx_d    = 1'b1;
          state_d = StIdle;
        end
      endcase

      // Start point may override the stop-end return to idle (gap-free streaming).
      if (start_pt && hold_full_q) begin
        hold_full_d = 1'b0;
        if (cfg_illegal) begin
          cfg_err_d = 1'b1;
        end else begin
          state_d   = StStart;
          tx_d      = 1'b0;
          shift_d   = hold_data_q;
          len_d     = cfg_data_len;
          par_en_d  = (cfg_parity != 3'(ParNone));
          par_bit_d = par_calc;
          stop2_d   = cfg_stop2;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      hold_data_q  <= '0;
      hold_full_q  <= 1'b0;
      shift_q      <= '0;
      cnt_q        <= '0;
      len_q        <= '0;
      par_en_q     <= 1'b0;
      par_bit_q    <= 1'b0;
      stop2_q      <= 1'b0;
      stop_cnt_q   <= 1'b0;
      tx_q         <= 1'b1;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_data_q  <= hold_data_d;
      hold_full_q  <= hold_full_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      par_en_q     <= par_en_d;
      par_bit_q    <= par_bit_d;
      stop2_q      <= stop2_d;
      stop_cnt_q   <= stop_cnt_d;
      tx_q         <= tx_d;
      frame_done_q <= frame_done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign s.s_ready   = ~hold_full_q;
  assign tx          = tx_q;
  assign busy        = (state_q != StIdle);
  assign frame_done  = frame_done_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// Bench for uart_tx_frame_engine: directed and random frames checked per baud tick
// against a bit-list model of the line.
module tb_uart_tx_frame_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       baud_tick = 1'b0;
  logic [3:0] cfg_data_len = 4'd8;
  logic [2:0] cfg_parity = 3'd0;
  logic       cfg_stop2 = 1'b0;
  logic       tx, busy, frame_done, cfg_err;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic tx;
    logic busy;
    logic done;
    logic err;
  } exp_t;

  exp_t exp_q[$];
  bit   pending_done = 1'b0;

  uart_tx_frame_engine_if #(.DATA_MAX(9)) ifc ();

  uart_tx_frame_engine #(
    .DATA_MAX (9),
    .LEN_W    (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .baud_tick    (baud_tick),
    .cfg_data_len (cfg_data_len),
    .cfg_parity   (cfg_parity),
    .cfg_stop2    (cfg_stop2),
    .s            (ifc),
    .tx           (tx),
    .busy         (busy),
    .frame_done   (frame_done),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Model: one entry per baud tick, describing the outputs right after that tick.
  function automatic void push_entry(input logic t, input logic b, input logic e);
    exp_t x;
    x.tx = t; x.busy = b; x.done = pending_done; x.err = e;
    pending_done = 1'b0;
    exp_q.push_back(x);
  endfunction

  function automatic void add_idle(input int n);
    for (int i = 0; i < n; i++) push_entry(1'b1, 1'b0, 1'b0);
  endfunction

  function automatic void add_frame(input logic [8:0] d, input int len, input int par,
                                    input bit s2);
    int ones = 0;
    if (len < 5 || len > 9 || par > 4) begin
      push_entry(1'b1, 1'b0, 1'b1);
      return;
    end
    push_entry(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < len; i++) begin
      ones += int'(d[i]);
      push_entry(d[i], 1'b1, 1'b0);
    end
    case (par)
      1: push_entry((ones % 2) == 0, 1'b1, 1'b0);
      2: push_entry((ones % 2) == 1, 1'b1, 1'b0);
      3: push_entry(1'b1, 1'b1, 1'b0);
      4: push_entry(1'b0, 1'b1, 1'b0);
      default: ;
    endcase
    push_entry(1'b1, 1'b1, 1'b0);
    if (s2) push_entry(1'b1, 1'b1, 1'b0);
    pending_done = 1'b1;
  endfunction

  task automatic do_tick(input int gap);
    exp_t x;
    logic tx_seen;
    x = '{tx: 1'b1, busy: 1'b0, done: 1'b0, err: 1'b0};
    if (exp_q.size() > 0) x = exp_q.pop_front();
    @(negedge clk) baud_tick = 1'b1;
    @(posedge clk);
    #1;
    check_val("tx", 32'(tx), 32'(x.tx));
    check_val("busy", 32'(busy), 32'(x.busy));
    check_val("frame_done", 32'(frame_done), 32'(x.done));
    check_val("cfg_err", 32'(cfg_err), 32'(x.err));
    tx_seen = tx;
    @(negedge clk) baud_tick = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      check_val("pulse_width", 32'({frame_done, cfg_err}), 32'(0));
      check_val("tx_hold", 32'(tx), 32'(tx_seen));
    end
  endtask

  task automatic run_ticks(input int gap_lo, input int gap_hi);
    while (exp_q.size() > 0) do_tick(int'($urandom_range(gap_hi, gap_lo)));
  endtask

  task automatic push(input logic [8:0] d);
    int  n = 0;
    bit  ok = 1'b0;
    @(negedge clk);
    ifc.s_valid = 1'b1;
    ifc.s_data  = d;
    while (!ok && n < 500) begin
      if (ifc.s_ready) ok = 1'b1;
      @(negedge clk);
      n++;
    end
    ifc.s_valid = 1'b0;
    ifc.s_data  = 9'($urandom);
    if (!ok) check_val("push_timeout", 32'(0), 32'(1));
  endtask

  task automatic set_cfg(input int len, input int par, input bit s2);
    cfg_data_len = 4'(len);
    cfg_parity   = 3'(par);
    cfg_stop2    = s2;
  endtask

  task automatic single(input logic [8:0] d, input int len, input int par, input bit s2,
                        input int gap_lo, input int gap_hi);
    set_cfg(len, par, s2);
    push(d);
    check_val("ready_full", 32'(ifc.s_ready), 32'(0));
    add_frame(d, len, par, s2);
    add_idle(2);
    run_ticks(gap_lo, gap_hi);
    check_val("ready_idle", 32'(ifc.s_ready), 32'(1));
  endtask

  // Second word is offered while the first frame runs; config switches after its start.
  task automatic back2back(input logic [8:0] d1, input int l1, input int p1, input bit s1,
                           input logic [8:0] d2, input int l2, input int p2, input bit s2);
    set_cfg(l1, p1, s1);
    push(d1);
    add_frame(d1, l1, p1, s1);
    add_frame(d2, l2, p2, s2);
    add_idle(2);
    fork
      push(d2);
      begin
        do_tick(1);
        set_cfg(l2, p2, s2);
        run_ticks(1, 3);
      end
    join
  endtask

  function automatic void rand_cfg(output int len, output int par, output bit s2);
    len = ($urandom % 8 == 0) ? int'($urandom_range(4, 0)) : int'($urandom_range(9, 5));
    if ($urandom % 10 == 0) len = int'($urandom_range(15, 10));
    par = ($urandom % 8 == 0) ? int'($urandom_range(7, 5)) : int'($urandom_range(4, 0));
    s2  = 1'($urandom);
  endfunction

  initial begin
    int l1, p1, l2, p2;
    bit s1, s2;
    ifc.s_valid = 1'b0;
    ifc.s_data  = '0;
    #23;
    check_val("rst_tx", 32'(tx), 32'(1));
    check_val("rst_ready", 32'(ifc.s_ready), 32'(1));
    check_val("rst_busy", 32'(busy), 32'(0));
    check_val("rst_done", 32'({frame_done, cfg_err}), 32'(0));
    @(negedge clk) rst = 1'b1;

    // Directed cases
    single(9'h055, 8, 0, 1'b0, 15, 15);
    single(9'h041, 7, 2, 1'b1, 1, 3);
    single(9'h041, 7, 1, 1'b1, 1, 3);
    single(9'h1ff, 9, 4, 1'b0, 1, 3);
    single(9'h0a5, 4, 0, 1'b0, 1, 3);
    single(9'h0a5, 8, 6, 1'b0, 1, 3);
    back2back(9'h0c3, 8, 0, 1'b0, 9'h13c, 8, 0, 1'b0);
    back2back(9'h0f0, 8, 0, 1'b0, 9'h03f, 5, 3, 1'b0);

    // Reset during DATA with a second word held
    set_cfg(8, 0, 1'b0);
    push(9'h0b7);
    add_frame(9'h0b7, 8, 0, 1'b0);
    do_tick(1);
    push(9'h1c2);
    for (int i = 0; i < 3; i++) do_tick(1);
    @(negedge clk) rst = 1'b0;
    #1;
    check_val("rst_mid_tx", 32'(tx), 32'(1));
    check_val("rst_mid_ready", 32'(ifc.s_ready), 32'(1));
    check_val("rst_mid_busy", 32'(busy), 32'(0));
    exp_q.delete();
    pending_done = 1'b0;
    @(negedge clk) rst = 1'b1;
    add_idle(4);
    run_ticks(1, 2);

    // Random frames and pairs
    for (int it = 0; it < 40; it++) begin
      rand_cfg(l1, p1, s1);
      if ($urandom % 2 == 0) begin
        single(9'($urandom), l1, p1, s1, 1, 3);
      end else begin
        rand_cfg(l2, p2, s2);
        back2back(9'($urandom), l1, p1, s1, 9'($urandom), l2, p2, s2);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame_engine.md
# uart_tx_frame_engine

Parametrised UART transmit engine. It accepts data words over a valid/ready handshake and buffers one word. It builds the frame from a per-frame runtime configuration (data length, parity mode, stop bits) and serialises it LSB-first on `tx`, one bit per `baud_tick`. It sits between the TX FIFO/host interface and the line driver. It supersedes the combinational frame builder: framing, parity and bit timing now live in one sequential block.

## Interface
- `DATA_MAX`, 9: maximum data bits per frame; legal range 5..9.
- `LEN_W`, 4: width of `cfg_data_len`.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `baud_tick` input 1: single-`clk` strobe, one per bit period.
- `cfg_data_len` input LEN_W: data bits per frame; legal 5..DATA_MAX.
- `cfg_parity` input 3: parity mode. 0 none, 1 odd, 2 even, 3 mark (1), 4 space (0). Values 5–7 are illegal.
- `cfg_stop2` input 1: 0 = one stop bit, 1 = two stop bits.
- `s_data` input DATA_MAX: word to send; bits above `cfg_data_len` are ignored.
- `s_valid` input 1: `s_data` is valid.
- `s_ready` output 1: holding register is empty.
- `tx` output 1: serial line, idle high.
- `busy` output 1: a frame is in progress (state ≠ IDLE).
- `frame_done` output 1: one-`clk` pulse when the last stop bit ends.
- `cfg_err` output 1: one-`clk` pulse when a word is dropped for illegal configuration.

## Operation
- **Holding register (1 deep).**
  - A word is accepted on a `clk` edge where `s_valid && s_ready`.
  - `s_ready = ~hold_full`, taken straight from the flop. There is no combinational bypass.
- **Frame start.**
  - On `baud_tick` with the state in IDLE (or finishing the last stop bit) and `hold_full` set:
    - the configuration is sampled;
    - the word moves into the shift register;
    - `hold_full` is cleared.
  - Configuration is frozen for the whole frame. Changes mid-frame affect only the next frame.
- **Illegal configuration.** If `cfg_data_len` < 5, `cfg_data_len` > DATA_MAX, or `cfg_parity` > 4 at the start point:
  - the word is discarded and `hold_full` is cleared;
  - `cfg_err` pulses;
  - the state stays IDLE and `tx` stays 1.
- **State machine.** States are IDLE, START, DATA, PARITY, STOP. All transitions occur on `baud_tick` only.
  - IDLE → START: a legal start; `tx` = 0.
  - START → DATA: `tx` = bit0.
  - DATA shifts LSB-first and counts `cfg_data_len` bits. After the last bit:
    - → PARITY if mode ≠ none;
    - → STOP otherwise.
  - PARITY: `tx` = parity bit. Then → STOP.
  - STOP lasts 1 or 2 bit periods with `tx` = 1. At its end:
    - `frame_done` pulses;
    - → START directly if `hold_full` is set and the config is legal (back-to-back frames, no idle gap);
    - → IDLE otherwise.
- **Parity** is computed over the `cfg_data_len` low bits only (masked XOR reduction).
  - Odd: the total count of ones, data plus parity, is odd.
  - Even: the total count is even.
- **Frame length** is 1 + N + P + S bit periods, where P ∈ {0,1} and S ∈ {1,2}. The maximum is 1+9+1+2 = 13.
- **Bit counter** width is $clog2(DATA_MAX+1). The counter never wraps past N.
- **Reset.**
  - Reset values: `tx`=1, `s_ready`=1, `busy`=0, `frame_done`=0, `cfg_err`=0. State is IDLE and the holding register is empty.
  - Reset asserted mid-frame aborts the frame immediately (asynchronously) and discards the held word.

## Timing
- `tx` is registered and changes only on the `clk` edge where `baud_tick`=1.
- Latency from accept to start bit: the first `baud_tick` after the accepting edge. A tick on the same edge as the accept does not start the frame.
- A new word may be accepted on the `clk` after the frame start that emptied the holding register. This keeps back-to-back streaming gap-free.
- `busy` rises on the same edge as the start bit. It falls on the edge ending the last stop bit unless a next frame starts on that edge.
- `frame_done` and `cfg_err` are registered, one cycle wide, and asserted on the `baud_tick` edge.
- `s_valid` held with `s_ready`=0 must be tolerated indefinitely. `s_data` is sampled only on acceptance.

## Structure
- Shared package `uart_pkg`:
  - parity mode enum `uart_parity_e` (NONE, ODD, EVEN, MARK, SPACE);
  - state enum `tx_state_e`;
  - constants `UART_MIN_DATA`=5 and `UART_MAX_FRAME`=13.
- One sub-module, `uart_parity_gen`: combinational masked parity, taking data, length and mode and producing the parity bit and an `illegal` flag. It is reused by the future RX checker.

## Test plan
- **8N1 single word.** 8N1, 0x55, tick every 16 clk. `tx` = 0,1,0,1,0,1,0,1,0,1 over 10 ticks, then stays 1; one `frame_done` pulse; `busy` high for exactly 10 ticks.
- **7E2 and 7O2.** 7E2, 0x41 (two ones) → parity 0, then stop 1,1; frame is 11 ticks. 7O2, same word → parity 1. For 9-bit space parity, `s_data`=0x1FF → bits all 1, parity 0.
- **Back-to-back.** Two words presented with `s_valid` continuously high, 8N1. The second start bit immediately follows the first stop bit (20 consecutive ticks, no idle). `s_ready` deasserts only while the holding register is full.
- **Mid-frame config change.** Change config mid-frame from 8N1 to 5M1. The current frame completes as 8N1. The next frame, 0x3F, sends 5 data bits (1,1,1,1,1) + mark 1 + stop.
- **Illegal config.** `cfg_data_len`=4 or `cfg_parity`=6 → `cfg_err` pulses once on the next tick; `tx` stays 1; `s_ready` returns to 1; no `frame_done`.
- **Reset mid-operation.** Reset during the DATA state of a frame with another word held. `tx`=1 and `s_ready`=1 immediately; after release, nothing is transmitted until a new accept.
